// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
// Receive-side monitor for a multiplexed NDIG-digit 7-segment display driver.
// It watches the anode-select and segment buses and waits for each digit to
// dwell stably. It then decodes the segment pattern back to a hex nibble and,
// once every digit of a scan frame has been captured, publishes the
// reassembled value.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   clr      in   1       synchronous active-high reset
//   an       in   NDIG    anode select, active-low; bit i = digit i (bit 0 = LS nibble)
//   a_to_g   in   7       segments, active-low; bit 6 = seg a ... bit 0 = seg g
//   x        out  4*NDIG  last completely captured value; nibble i = digit i
//   x_valid  out  1       one-cycle pulse when x is updated
//   seg_err  out  1       one-cycle pulse when a stable digit has an undecodable pattern
// -----------------------------------------------------------------------------
module seg7_capture #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NDIG-1:0]     an,
    input  logic [6:0]          a_to_g,
    output logic [4*NDIG-1:0]   x,
    output logic                x_valid,
    output logic                seg_err
);

    localparam int unsigned DW    = 4 * NDIG;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned OFS_W = IDX_W + 2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE - 1);

    // Active-low segment pattern -> {valid, nibble}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Registers
    logic [NDIG-1:0]  prev_an_q;
    logic [6:0]       prev_seg_q;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             sampled_q, sampled_d;
    logic [NDIG-1:0]  mask_q,    mask_d;
    logic [DW-1:0]    shadow_q,  shadow_d;
    logic [DW-1:0]    x_q,       x_d;
    logic             x_valid_q, x_valid_d;
    logic             seg_err_q, seg_err_d;

    // Combinational intermediates
    logic             bus_change;
    logic             sample_ev;
    logic [NDIG-1:0]  an_act;
    logic             dig_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic [OFS_W-1:0] sel_ofs;
    logic [4:0]       dec;
    logic [NDIG-1:0]  mask_new;
    logic [DW-1:0]    shadow_new;

    // Input history for change detection; tracks the buses even in reset so a
    // bus that is simply held across reset is not mistaken for a new dwell.
    always_ff @(posedge clk) begin
        prev_an_q  <= an;
        prev_seg_q <= a_to_g;
    end

    // Dwell timer: one sample per stable dwell, taken once STABLE cycles elapse
    always_comb begin
        bus_change = (an != prev_an_q) || (a_to_g != prev_seg_q);
        cnt_d      = cnt_q;
        sampled_d  = sampled_q;
        sample_ev  = 1'b0;
        if (bus_change) begin
            cnt_d     = '0;
            sampled_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!sampled_q && (cnt_q == CNT_HIT)) begin
                sample_ev = 1'b1;
                sampled_d = 1'b1;
            end
        end
    end

    // Digit selection: only a single active anode addresses a digit
    always_comb begin
        an_act     = ~prev_an_q;
        dig_onehot = (an_act != '0) && ((an_act & (an_act - NDIG'(1))) == '0);
        sel_idx    = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (an_act[k]) begin
                sel_idx = IDX_W'(k);
            end
        end
        sel_ofs = {sel_idx, 2'b00};
        dec     = seg_decode(prev_seg_q);
    end

    // Capture, frame assembly and output pulses
    always_comb begin
        mask_d     = mask_q;
        shadow_d   = shadow_q;
        x_d        = x_q;
        x_valid_d  = 1'b0;
        seg_err_d  = 1'b0;
        mask_new   = mask_q;
        shadow_new = shadow_q;
        if (sample_ev && dig_onehot) begin
            if (dec[4]) begin
                shadow_new[sel_ofs +: 4] = dec[3:0];
                mask_new                 = mask_q | (NDIG'(1) << sel_idx);
                shadow_d                 = shadow_new;
                if (&mask_new) begin
                    // Frame complete: publish including the digit just taken
                    x_d       = shadow_new;
                    x_valid_d = 1'b1;
                    mask_d    = '0;
                end else begin
                    mask_d = mask_new;
                end
            end else begin
                seg_err_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q     <= '0;
            sampled_q <= 1'b1;
            mask_q    <= '0;
            shadow_q  <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sampled_q <= sampled_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            seg_err_q <= seg_err_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign seg_err = seg_err_q;

endmodule
